// File: rtl/div_cycle_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings and sizing constants.
package div_cycle_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    DIV_ST_IDLE = 3'd0,
    DIV_ST_PREP = 3'd1,
    DIV_ST_CALC = 3'd2,
    DIV_ST_FIX  = 3'd3,
    DIV_ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_cycle_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_cycle_if
  import div_cycle_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, dividend, divisor, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/div_cycle_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step
  import div_cycle_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH-1:0] shifted;
  logic             geq;

  assign shifted = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};

  // The bit shifted out of rem_in is the top bit of the WIDTH+1 partial remainder;
  // when set it already exceeds any divisor, and the wrapped difference is exact.
  assign geq     = rem_in[WIDTH-1] | (shifted >= d);
  assign rem_out = geq ? (shifted - d) : shifted;
  assign quo_out = {quo_in[WIDTH-2:0], geq};

endmodule

// File: rtl/div_cycle.sv
// Multi-cycle MIPS DIV/DIVU unit: quotient on lo, remainder on hi, done pulses once per operation.
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero skips the iterations and completes from PREP.
module div_cycle
  import div_cycle_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  div_cycle_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, d_q;
  logic             sgn_q, q_neg_q, r_neg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] rem_d, quo_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .d       (d_q),
    .rem_out (rem_d),
    .quo_out (quo_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so hi/lo and the operand regs are never X after reset.
      state_q <= DIV_ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      d_q     <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.cancel) begin
      state_q <= DIV_ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (bus.start) begin
            quo_q   <= bus.dividend;
            d_q     <= bus.divisor;
            sgn_q   <= bus.is_signed;
            busy_q  <= 1'b1;
            state_q <= DIV_ST_PREP;
          end
        end
        DIV_ST_PREP: begin
          // Raw operands sit in quo_q/d_q until here; replace them with magnitudes.
          rem_q   <= '0;
          quo_q   <= magnitude(quo_q, sgn_q);
          d_q     <= magnitude(d_q, sgn_q);
          q_neg_q <= sgn_q & (quo_q[WIDTH-1] ^ d_q[WIDTH-1]);
          r_neg_q <= sgn_q & quo_q[WIDTH-1];
          cnt_q   <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
          if (d_q == '0) begin
            lo_q    <= '1;
            hi_q    <= quo_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DIV_ST_DONE;
          end else begin
            state_q <= DIV_ST_CALC;
          end
`else
          state_q <= DIV_ST_CALC;
`endif
        end
        DIV_ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= DIV_ST_FIX;
        end
        DIV_ST_FIX: begin
          lo_q    <= q_neg_q ? -quo_q : quo_q;
          hi_q    <= r_neg_q ? -rem_q : rem_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= DIV_ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_div_cycle.sv
// Scoreboard bench for div_cycle: stimulus pushes expected hi/lo/done-cycle, a monitor pops on done.
module tb_div_cycle;
  import div_cycle_pkg::*;

  localparam int W = DIV_WIDTH;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 35;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  div_cycle_if #(.WIDTH(W)) bus ();

  div_cycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    string          name;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    int unsigned    at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_lo"},    64'(bus.lo),   64'(mon_e.lo));
        check({mon_e.name, "_hi"},    64'(bus.hi),   64'(mon_e.hi));
        check({mon_e.name, "_cycle"}, 64'(edge_cnt), 64'(mon_e.at));
        check({mon_e.name, "_busy"},  64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input int lat, input bit chk_busy);
    exp_t e;
    @(negedge clk);
    drive(a, b, s);
    e.name = name;
    e.lo   = elo;
    e.hi   = ehi;
    e.at   = edge_cnt + lat;
    exp_q.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (chk_busy) check($sformatf("%s_busy_c%0d", name, k), 64'(bus.busy), 64'(k < lat));
    end
    last_lo = elo;
    last_hi = ehi;
  endtask

  initial begin
    exp_t e;
    bus.start     = 1'b0;
    bus.cancel    = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    rst_n = 1'b1;

    run_op("divu_100_7", 32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          35, 1'b1);
    run_op("div_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  35, 1'b0);
    run_op("divu_m7_2",  32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          35, 1'b0);
    run_op("div_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          35, 1'b0);
    run_op("div_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          35, 1'b0);
    run_op("divu_max_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          35, 1'b0);
    run_op("divu_5_0",   32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          ZLAT, 1'b0);

    // Cancel mid-CALC: outputs hold, no done, next operation runs normally.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_done", 64'(bus.done), 64'd0);
    check("cancel_lo",   64'(bus.lo),   64'(last_lo));
    check("cancel_hi",   64'(bus.hi),   64'(last_hi));
    run_op("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 35, 1'b0);

    // Start and cancel together in IDLE: cancel wins.
    @(negedge clk);
    drive(32'd8, 32'd2, 1'b0);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel_busy", 64'(bus.busy), 64'd0);

    // Extra starts while busy and during DONE are dropped.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0);
    e.name = "divu_restart";
    e.lo   = 32'd14;
    e.hi   = 32'd2;
    e.at   = edge_cnt + 35;
    exp_q.push_back(e);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      bus.start = (k == 5 || k == 35);
      if (bus.start) begin
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_ignored_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of CALC clears outputs immediately.
    @(negedge clk);
    drive(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midcalc_busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hi",   64'(bus.hi),   64'd0);
    check("arst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 35, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
